// File: rtl/cc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cc_unit
//  Description : Condition-code register (ZF/SF/OF) and Y86 condition
//                evaluator for the SEQ execute stage. Flags are captured
//                from the ALU on set_cc. Condition queries for jXX/cmovXX
//                are answered one cycle later with registered cnd,
//                cnd_valid and cond_err.
//                Optional macro CC_BYPASS_EN: when set_cc and cond_req
//                coincide, evaluate on the flags being written that edge.
//  Revision    : 1.0  initial release
// ============================================================================
module cc_unit #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   alu_ctrl,
    input  logic [W-1:0] alu_result,
    input  logic         alu_overflow,
    input  logic         set_cc,
    input  logic         cond_req,
    input  logic [3:0]   cond_ifun,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         cnd,
    output logic         cnd_valid,
    output logic         cond_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic [1:0] c_ALU_SUB = 2'd1;

    state_t r_state;
    state_t w_state_nxt;

    logic r_zf, r_sf, r_of;
    logic r_cnd, r_cond_err;

    logic w_new_zf, w_new_sf, w_new_of;
    logic w_eval_zf, w_eval_sf, w_eval_of;
    logic w_cnd_eval, w_err_eval;
    logic w_cnd_nxt, w_err_nxt;

    // Flags the ALU outputs would produce; logical ops never overflow.
    always_comb begin
        w_new_zf = (alu_result == '0);
        w_new_sf = alu_result[W-1];
        w_new_of = (alu_ctrl <= c_ALU_SUB) ? alu_overflow : 1'b0;
    end

`ifdef CC_BYPASS_EN
    // Forward the incoming flags when a query lands on the same edge as set_cc.
    always_comb begin
        w_eval_zf = set_cc ? w_new_zf : r_zf;
        w_eval_sf = set_cc ? w_new_sf : r_sf;
        w_eval_of = set_cc ? w_new_of : r_of;
    end
`else
    // Queries always see the flags as registered before this edge.
    always_comb begin
        w_eval_zf = r_zf;
        w_eval_sf = r_sf;
        w_eval_of = r_of;
    end
`endif

    // Y86 condition decode; ifun 7..15 are undefined and flag an error.
    always_comb begin
        w_cnd_eval = 1'b0;
        w_err_eval = 1'b0;
        case (cond_ifun)
            4'd0:    w_cnd_eval = 1'b1;
            4'd1:    w_cnd_eval = (w_eval_sf ^ w_eval_of) | w_eval_zf;
            4'd2:    w_cnd_eval = w_eval_sf ^ w_eval_of;
            4'd3:    w_cnd_eval = w_eval_zf;
            4'd4:    w_cnd_eval = ~w_eval_zf;
            4'd5:    w_cnd_eval = ~(w_eval_sf ^ w_eval_of);
            4'd6:    w_cnd_eval = ~(w_eval_sf ^ w_eval_of) & ~w_eval_zf;
            default: w_err_eval = 1'b1;
        endcase
    end

    // Flag register; resets to the architectural initial state ZF=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (set_cc) begin
            r_zf <= w_new_zf;
            r_sf <= w_new_sf;
            r_of <= w_new_of;
        end
    end

    // Query FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and response values; a query in either state yields RESP.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnd_nxt   = r_cnd;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cond_req) begin
                    w_state_nxt = ST_RESP;
                    w_cnd_nxt   = w_cnd_eval;
                    w_err_nxt   = w_err_eval;
                end
            end
            ST_RESP: begin
                if (cond_req) begin
                    w_state_nxt = ST_RESP;
                    w_cnd_nxt   = w_cnd_eval;
                    w_err_nxt   = w_err_eval;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Response registers; cnd holds between queries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnd      <= 1'b0;
            r_cond_err <= 1'b0;
        end else begin
            r_cnd      <= w_cnd_nxt;
            r_cond_err <= w_err_nxt;
        end
    end

    assign zf        = r_zf;
    assign sf        = r_sf;
    assign of        = r_of;
    assign cnd       = r_cnd;
    assign cnd_valid = (r_state == ST_RESP);
    assign cond_err  = r_cond_err;

endmodule
`default_nettype wire

// File: tb/tb_cc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc_unit
//  Description : Self-checking bench for cc_unit. A behavioural model tracks
//                flags and query responses; a compare process checks every
//                cycle, and directed scenarios pin literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cc_unit;

    localparam int W = 64;
`ifdef CC_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif
    localparam logic [W-1:0] c_MIN = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   alu_ctrl = '0;
    logic [W-1:0] alu_result = '0;
    logic         alu_overflow = 1'b0;
    logic         set_cc = 1'b0;
    logic         cond_req = 1'b0;
    logic [3:0]   cond_ifun = '0;
    logic         zf, sf, of, cnd, cnd_valid, cond_err;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    always #5 clk = ~clk;

    cc_unit #(.W(W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .set_cc       (set_cc),
        .cond_req     (cond_req),
        .cond_ifun    (cond_ifun),
        .zf           (zf),
        .sf           (sf),
        .of           (of),
        .cnd          (cnd),
        .cnd_valid    (cnd_valid),
        .cond_err     (cond_err)
    );

    // ---------------- behavioural model ----------------
    bit m_init = 1'b0;
    bit m_zf, m_sf, m_of, m_cnd, m_valid, m_err;

    // Y86 condition truth: "less" in signed terms means SF differs from OF.
    // Returns {err, cnd}.
    function automatic logic [1:0] truth(int ifun, bit z, bit s, bit o);
        bit less;
        less = (s != o);
        case (ifun)
            0: return 2'b01;
            1: return {1'b0, less || z};
            2: return {1'b0, less};
            3: return {1'b0, z};
            4: return {1'b0, !z};
            5: return {1'b0, !less};
            6: return {1'b0, !less && !z};
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] answer(bit set, logic [W-1:0] res, logic [1:0] ctrl,
                                          bit ovf, int ifun, bit z, bit s, bit o);
        if (c_BYP && set)
            return truth(ifun, res == 0, $signed(res) < 0, (ctrl < 2) ? ovf : 1'b0);
        return truth(ifun, z, s, o);
    endfunction

    always @(posedge clk) begin
        m_init <= 1'b1;
        if (rst) begin
            m_zf <= 1'b1; m_sf <= 1'b0; m_of <= 1'b0;
            m_cnd <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0;
        end else begin
            m_valid <= cond_req;
            m_err   <= cond_req ? answer(set_cc, alu_result, alu_ctrl, alu_overflow,
                                         int'(cond_ifun), m_zf, m_sf, m_of) >> 1 : 1'b0;
            if (cond_req)
                m_cnd <= answer(set_cc, alu_result, alu_ctrl, alu_overflow,
                                int'(cond_ifun), m_zf, m_sf, m_of) & 2'b01;
            if (set_cc) begin
                m_zf <= (alu_result == 0);
                m_sf <= ($signed(alu_result) < 0);
                m_of <= (alu_ctrl < 2) ? alu_overflow : 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        while (!done) begin
            @(negedge clk);
            if (m_init) begin
                chk("model.zf", zf, m_zf);
                chk("model.sf", sf, m_sf);
                chk("model.of", of, m_of);
                chk("model.cnd", cnd, m_cnd);
                chk("model.cnd_valid", cnd_valid, m_valid);
                chk("model.cond_err", cond_err, m_err);
            end
        end
    endtask

    // Drive one cycle of inputs; returns 2 time units after the sampling edge.
    task automatic cyc(bit r, bit s, logic [1:0] ctrl, logic [W-1:0] res, bit ovf,
                       bit q, logic [3:0] ifun);
        rst = r; set_cc = s; alu_ctrl = ctrl; alu_result = res; alu_overflow = ovf;
        cond_req = q; cond_ifun = ifun;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 2'd0, '0, 0, 0, 4'd0);
    endtask

    task automatic stimulus();
        logic [W-1:0] res;
        // Reset behaviour
        cyc(1, 0, 0, '0, 0, 0, 0);
        cyc(1, 0, 0, '0, 0, 0, 0);
        chk("rst.zf", zf, 1'b1); chk("rst.sf", sf, 1'b0); chk("rst.of", of, 1'b0);
        chk("rst.cnd_valid", cnd_valid, 1'b0); chk("rst.cnd", cnd, 1'b0);
        cyc(0, 0, 0, '0, 0, 1, 4'd3);
        chk("e_after_rst.cnd", cnd, 1'b1); chk("e_after_rst.valid", cnd_valid, 1'b1);
        idle();
        chk("single_pulse.valid", cnd_valid, 1'b0); chk("hold.cnd", cnd, 1'b1);
        // Add overflow into sign bit
        cyc(0, 1, 2'd0, c_MIN, 1, 0, 0);
        chk("addovf.zf", zf, 1'b0); chk("addovf.sf", sf, 1'b1); chk("addovf.of", of, 1'b1);
        cyc(0, 0, 0, '0, 0, 1, 4'd2);
        chk("l.cnd", cnd, 1'b0);
        cyc(0, 0, 0, '0, 0, 1, 4'd1);
        chk("le.cnd", cnd, 1'b0); chk("le.valid", cnd_valid, 1'b1);
        // Logical op clears OF
        cyc(0, 1, 2'd3, '0, 1, 0, 0);
        chk("xor.zf", zf, 1'b1); chk("xor.sf", sf, 1'b0); chk("xor.of", of, 1'b0);
        cyc(0, 0, 0, '0, 0, 1, 4'd6);
        chk("g.cnd", cnd, 1'b0);
        // Back-to-back queries with zf=0 sf=1 of=0
        cyc(0, 1, 2'd0, '1, 0, 0, 0);
        cyc(0, 0, 0, '0, 0, 1, 4'd4);
        chk("b2b0.valid", cnd_valid, 1'b1); chk("b2b0.cnd", cnd, 1'b1); chk("b2b0.err", cond_err, 1'b0);
        cyc(0, 0, 0, '0, 0, 1, 4'd5);
        chk("b2b1.valid", cnd_valid, 1'b1); chk("b2b1.cnd", cnd, 1'b0); chk("b2b1.err", cond_err, 1'b0);
        cyc(0, 0, 0, '0, 0, 1, 4'd9);
        chk("b2b2.valid", cnd_valid, 1'b1); chk("b2b2.cnd", cnd, 1'b0); chk("b2b2.err", cond_err, 1'b1);
        idle();
        chk("b2b_end.valid", cnd_valid, 1'b0); chk("b2b_end.err", cond_err, 1'b0);
        // Same-cycle set_cc and query
        cyc(0, 1, 2'd2, '0, 0, 0, 0);
        cyc(0, 1, 2'd0, 64'd5, 0, 1, 4'd3);
        chk("samecyc.cnd", cnd, c_BYP ? 1'b0 : 1'b1); chk("samecyc.zf", zf, 1'b0);
        // Reset mid-query
        cyc(1, 1, 2'd0, '0, 0, 1, 4'd0);
        chk("rstq.valid", cnd_valid, 1'b0); chk("rstq.cnd", cnd, 1'b0);
        chk("rstq.zf", zf, 1'b1); chk("rstq.sf", sf, 1'b0); chk("rstq.of", of, 1'b0);
        // MIN+MIN: zero result with overflow
        cyc(0, 1, 2'd0, '0, 1, 0, 0);
        chk("minmin.zf", zf, 1'b1); chk("minmin.of", of, 1'b1); chk("minmin.sf", sf, 1'b0);
        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       res = '0;
                1:       res = c_MIN;
                2:       res = {$urandom, $urandom};
                default: res = W'($urandom_range(0, 7));
            endcase
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)), res, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)));
        end
        idle();
        idle();
        done = 1'b1;
    endtask

    initial begin
        fork
            compare_loop();
            stimulus();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
